fifo_wr_arbiter: RTL and testbench

- Round-robin write-side arbiter that shares one 8-bit, 16-deep sync FIFO write port among N producers.
- Each producer has a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst.
- It drives the FIFO's wr/din directly and honours its full flag.
- Sits between producer blocks and the FIFO write interface.

---
 rtl/fifo_wr_arbiter_if.sv | 16 +
 rtl/fifo_wr_arbiter.sv | 51 +++++
 tb/tb_fifo_wr_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshakes and FIFO write port shared by the arbiter.
interface fifo_wr_arbiter_if #(parameter int N = 4, parameter int DW = 8);
  logic [N-1:0] req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0] req_en;
  logic [N-1:0] req_ready;
  logic fifo_full;
  logic fifo_wr;
  logic [DW-1:0] fifo_din;
  logic [$clog2(N)-1:0] grant_id;
  logic busy;
  modport master (input req_valid, req_data, req_en, fifo_full,
                  output req_ready, fifo_wr, fifo_din, grant_id, busy);
  modport slave (output req_valid, req_data, req_en, fifo_full,
                 input req_ready, fifo_wr, fifo_din, grant_id, busy);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N producers in bounded bursts.
module fifo_wr_arbiter #(
  parameter int N = 4,
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int GW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t st;
  logic [GW-1:0] g, last, nxt;
  logic [4:0] bcnt;
  logic [N-1:0] elig;
  logic act;
  always_comb begin
    elig = bus.req_valid & bus.req_en;
    nxt = last;
    // walk from farthest to nearest so the first eligible after last wins
    for (int i = N; i >= 1; i--)
      if (elig[(int'(last) + i) % N]) nxt = GW'((int'(last) + i) % N);
    act = st == GRANT && !rst && bus.req_en[g] && !bus.fifo_full;
    bus.req_ready = act ? N'(1) << g : '0;
    bus.fifo_wr = act && bus.req_valid[g];
    bus.fifo_din = bus.req_data[g*DW +: DW];
    bus.busy = st == GRANT;
    bus.grant_id = g;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      g <= '0;
      last <= GW'(N - 1);
      bcnt <= '0;
    end else if (st == IDLE) begin
      if (|elig) begin
        st <= GRANT;
        g <= nxt;
        last <= nxt;
        bcnt <= '0;
      end
    end else if (!bus.req_valid[g] || !bus.req_en[g]) begin
      st <= IDLE;
    end else if (bus.fifo_wr) begin
      bcnt <= bcnt + 5'd1;
      if (bcnt == 5'(MAX_BURST - 1)) st <= IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario tasks with a write scoreboard of expected {grant_id, data} beats.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  fifo_wr_arbiter_if ifc ();
  fifo_wr_arbiter dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];
  logic [7:0] base[4];
  int sent[4];
  int rem[4];
  logic [3:0] s_ready;
  logic s_busy, s_wr;
  logic [1:0] s_gid;
  logic [31:0] wp, bp;
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      ifc.req_valid[i] = rem[i] > 0;
      ifc.req_data[i*8 +: 8] = base[i] + 8'(sent[i]);
    end
  endtask
  task automatic push(input logic [1:0] id, input logic [7:0] d);
    sb.push_back({id, d});
  endtask
  task automatic tick();
    logic [3:0] acc;
    logic [9:0] e;
    @(negedge clk);
    s_wr = ifc.fifo_wr;
    s_ready = ifc.req_ready;
    s_busy = ifc.busy;
    s_gid = ifc.grant_id;
    acc = ifc.req_valid & ifc.req_ready;
    if (s_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: id=%0d din=%h written, required no write", s_gid, ifc.fifo_din);
      end else begin
        e = sb.pop_front();
        if ({s_gid, ifc.fifo_din} !== e) begin
          errors++;
          $display("FAIL sb_beat: got id=%0d din=%h, required id=%0d din=%h", s_gid, ifc.fifo_din, e[9:8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) begin
        sent[i]++;
        rem[i]--;
      end
    drive();
  endtask
  task automatic run(input int n);
    wp = '0;
    bp = '0;
    repeat (n) begin
      tick();
      wp = {wp[30:0], s_wr};
      bp = {bp[30:0], s_busy};
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      sent[i] = 0;
      base[i] = 8'(i * 16);
    end
    ifc.req_en = 4'hF;
    ifc.fifo_full = 1'b0;
    sb.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    rem[0] = 3;
    drive();
    @(negedge clk);
    checks += 3;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", ifc.busy); end
    if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", ifc.req_ready); end
    if (ifc.fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b, required 0", ifc.fifo_wr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_single();
    do_reset();
    base[0] = 8'hA0;
    rem[0] = 6;
    drive();
    for (int k = 0; k < 6; k++) push(2'd0, 8'hA0 + 8'(k));
    run(10);
    checks += 3;
    if (wp[9:0] !== 10'b0111101100) begin errors++; $display("FAIL single_wr_pattern: got %b, required 0111101100", wp[9:0]); end
    if (bp[9:0] !== 10'b0111101110) begin errors++; $display("FAIL single_busy_pattern: got %b, required 0111101110", bp[9:0]); end
    if (sb.size() != 0) begin errors++; $display("FAIL single_drain: %0d beats unwritten, required 0", sb.size()); end
  endtask
  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 8;
    drive();
    for (int k = 0; k < 20; k++) push(2'((k / 4) % 4), base[(k / 4) % 4] + 8'((k / 16) * 4 + k % 4));
    run(25);
    checks += 2;
    if (wp[24:0] !== 25'b0111101111011110111101111) begin errors++; $display("FAIL rr_wr_pattern: got %b, required 0111101111011110111101111", wp[24:0]); end
    if (sb.size() != 0) begin errors++; $display("FAIL rr_drain: %0d beats unwritten, required 0", sb.size()); end
  endtask
  task automatic test_full_stall();
    do_reset();
    base[2] = 8'hC0;
    rem[2] = 4;
    drive();
    for (int k = 0; k < 4; k++) push(2'd2, 8'hC0 + 8'(k));
    run(3);
    ifc.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 3;
      if (s_ready !== 4'b0) begin errors++; $display("FAIL stall_ready: got %b, required 0000", s_ready); end
      if (s_wr !== 1'b0) begin errors++; $display("FAIL stall_wr: got %b, required 0", s_wr); end
      if (s_busy !== 1'b1 || s_gid !== 2'd2) begin errors++; $display("FAIL stall_grant: got busy=%b id=%0d, required busy=1 id=2", s_busy, s_gid); end
    end
    ifc.fifo_full = 1'b0;
    run(3);
    checks += 3;
    if (wp[2:0] !== 3'b110) begin errors++; $display("FAIL stall_resume_wr: got %b, required 110", wp[2:0]); end
    if (bp[2:0] !== 3'b110) begin errors++; $display("FAIL stall_resume_busy: got %b, required 110", bp[2:0]); end
    if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: %0d beats unwritten, required 0", sb.size()); end
  endtask
  task automatic test_early_release();
    do_reset();
    rem[1] = 2;
    rem[3] = 4;
    drive();
    push(2'd1, 8'h10);
    push(2'd1, 8'h11);
    for (int k = 0; k < 4; k++) push(2'd3, 8'h30 + 8'(k));
    run(5);
    checks += 2;
    if (wp[4:0] !== 5'b01100) begin errors++; $display("FAIL early_wr: got %b, required 01100", wp[4:0]); end
    if (bp[4:0] !== 5'b01110) begin errors++; $display("FAIL early_busy: got %b, required 01110", bp[4:0]); end
    tick();
    checks++;
    if (s_busy !== 1'b1 || s_gid !== 2'd3) begin errors++; $display("FAIL early_regrant: got busy=%b id=%0d, required busy=1 id=3", s_busy, s_gid); end
    run(3);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL early_drain: %0d beats unwritten, required 0", sb.size()); end
  endtask
  task automatic test_enable_mask();
    logic [1:0] ord[4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    do_reset();
    ifc.req_en = 4'b1011;
    for (int i = 0; i < 4; i++) rem[i] = 8;
    drive();
    for (int k = 0; k < 16; k++) push(ord[k / 4], base[ord[k / 4]] + 8'((k / 12) * 4 + k % 4));
    push(2'd1, 8'h14);
    run(20);
    checks++;
    if (wp[19:0] !== 20'b01111011110111101111) begin errors++; $display("FAIL mask_wr_pattern: got %b, required 01111011110111101111", wp[19:0]); end
    run(2);
    ifc.req_en = 4'b1001;
    tick();
    checks += 2;
    if (s_wr !== 1'b0 || s_ready !== 4'b0) begin errors++; $display("FAIL mask_drop: got wr=%b ready=%b, required wr=0 ready=0000", s_wr, s_ready); end
    if (s_busy !== 1'b1 || s_gid !== 2'd1) begin errors++; $display("FAIL mask_drop_grant: got busy=%b id=%0d, required busy=1 id=1", s_busy, s_gid); end
    tick();
    checks += 2;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL mask_idle: got busy=%b, required 0", s_busy); end
    if (sb.size() != 0) begin errors++; $display("FAIL mask_drain: %0d beats unwritten, required 0", sb.size()); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    rem[3] = 8;
    drive();
    push(2'd3, 8'h30);
    push(2'd3, 8'h31);
    push(2'd1, 8'h10);
    run(3);
    rst = 1'b1;
    rem[1] = 4;
    drive();
    tick();
    checks++;
    if (s_wr !== 1'b0 || s_ready !== 4'b0) begin errors++; $display("FAIL rstmid_wr: got wr=%b ready=%b, required wr=0 ready=0000", s_wr, s_ready); end
    rst = 1'b0;
    tick();
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", s_busy); end
    tick();
    checks += 2;
    if (s_busy !== 1'b1 || s_gid !== 2'd1) begin errors++; $display("FAIL rstmid_grant: got busy=%b id=%0d, required busy=1 id=1", s_busy, s_gid); end
    if (sb.size() != 0) begin errors++; $display("FAIL rstmid_drain: %0d beats unwritten, required 0", sb.size()); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_full_stall();
    test_early_release();
    test_enable_mask();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
